// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in EX.
// Produces {remainder, quotient} and stalls the pipeline while a division is in flight.
module div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_div,
  input  logic [WIDTH-1:0]     opdata1,
  input  logic [WIDTH-1:0]     opdata2,
  input  logic                 annul,
  input  logic                 hold,
  output logic [2*WIDTH-1:0]   result,
  output logic                 ready,
  output logic                 stall_req_ex
);

  localparam int unsigned RES_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BY_ZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t            state;
  logic [RES_W-1:0]  rem_q;
  logic [WIDTH-1:0]  divisor_q;
  logic              signed_q;
  logic              sign_a_q;
  logic              sign_b_q;
  logic [CNT_W-1:0]  cnt;

  logic [RES_W:0]    shifted;
  logic              trial_ge;
  logic [WIDTH-1:0]  trial_diff;
  logic [RES_W-1:0]  step_rem;
  logic [WIDTH-1:0]  q_raw;
  logic [WIDTH-1:0]  r_raw;
  logic [WIDTH-1:0]  q_fix;
  logic [WIDTH-1:0]  r_fix;
  logic              neg_in_a;
  logic              neg_in_b;
  logic [WIDTH-1:0]  abs_a;
  logic [WIDTH-1:0]  abs_b;

  // One restoring step: shift, trial-subtract the divisor from the upper half, set quotient bit.
  always_comb begin
    shifted    = {rem_q, 1'b0};
    trial_ge   = (shifted[RES_W:WIDTH] >= {1'b0, divisor_q});
    trial_diff = shifted[RES_W-1:WIDTH] - divisor_q;
    step_rem   = trial_ge ? {trial_diff, shifted[WIDTH-1:1], 1'b1} : shifted[RES_W-1:0];
    q_raw      = step_rem[WIDTH-1:0];
    r_raw      = step_rem[RES_W-1:WIDTH];
    q_fix      = (signed_q && (sign_a_q != sign_b_q)) ? -q_raw : q_raw;
    r_fix      = (signed_q && sign_a_q) ? -r_raw : r_raw;
  end

  // Magnitudes of the incoming operands; only signed division negates.
  always_comb begin
    neg_in_a = signed_div & opdata1[WIDTH-1];
    neg_in_b = signed_div & opdata2[WIDTH-1];
    abs_a    = neg_in_a ? -opdata1 : opdata1;
    abs_b    = neg_in_b ? -opdata2 : opdata2;
  end

  assign stall_req_ex = start & ~ready & ~annul;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ready     <= 1'b0;
      result    <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      signed_q  <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
    end else if (annul) begin
      state <= S_IDLE;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt      <= '0;
            signed_q <= signed_div;
            sign_a_q <= opdata1[WIDTH-1];
            sign_b_q <= opdata2[WIDTH-1];
            if (opdata2 == '0) begin
              state <= S_BY_ZERO;
            end else begin
              state     <= S_ON;
              rem_q     <= {WIDTH'(0), abs_a};
              divisor_q <= abs_b;
            end
          end
        end
        S_BY_ZERO: begin
          state  <= S_END;
          ready  <= 1'b1;
          result <= '0;
        end
        S_ON: begin
          rem_q <= step_rem;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state  <= S_END;
            ready  <= 1'b1;
            result <= {r_fix, q_fix};
          end
        end
        S_END: begin
          // A later-stage stall keeps the result presented until EX can take it.
          if (!hold) begin
            state <= S_IDLE;
            ready <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
